// File: rtl/audio_fir_sequencer.sv
// Handshake sequencer between codec sample FIFOs and a stereo pair of N-tap moving-average filters.
// Define AUDIO_FIR_BYPASS_EN to route samples around the filters (filter strobes tied low).
module audio_fir_sequencer #(
    parameter int unsigned N = 1024,
    parameter int unsigned W = 24
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         read_ready,
    output logic         read,
    input  logic [W-1:0] readdata_left,
    input  logic [W-1:0] readdata_right,
    input  logic         write_ready,
    output logic         write,
    output logic [W-1:0] writedata_left,
    output logic [W-1:0] writedata_right,
    output logic         filt_wren,
    output logic         filt_reen,
    output logic         filt_clear,
    output logic [W-1:0] filt_in_left,
    output logic [W-1:0] filt_in_right,
    input  logic [W-1:0] filt_out_left,
    input  logic [W-1:0] filt_out_right
);

`ifdef AUDIO_FIR_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    localparam int unsigned CW = $clog2(N) + 1;
    localparam logic [CW-1:0] FullCount = CW'(N);

    typedef enum logic [1:0] {StClear, StIdle, StFeed, StDrain} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [W-1:0]  sample_l_q, sample_l_d, sample_r_q, sample_r_d;
    logic [W-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic          wren_q, wren_d, reen_q, reen_d, clear_q, clear_d;

    // read/write are pop/push strobes that must coincide with the ready they answer,
    // so they are decoded from the state register and the ready input in the same cycle.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        sample_l_d = sample_l_q;
        sample_r_d = sample_r_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        read       = 1'b0;
        write      = 1'b0;
        unique case (state_q)
            StClear: state_d = StIdle;
            StIdle: begin
                if (read_ready && !Reset) begin
                    read       = 1'b1;
                    sample_l_d = readdata_left;
                    sample_r_d = readdata_right;
                    state_d    = StFeed;
                end
            end
            StFeed: begin
                hold_l_d = BypassEn ? sample_l_q : filt_out_left;
                hold_r_d = BypassEn ? sample_r_q : filt_out_right;
                if (!BypassEn && fill_q != FullCount) begin
                    fill_d = fill_q + CW'(1);
                end
                state_d = StDrain;
            end
            StDrain: begin
                if (write_ready && !Reset) begin
                    write   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StClear;
        endcase
        // Filter strobes are registered to line up with the state they belong to.
        wren_d  = !BypassEn && (state_d == StFeed);
        reen_d  = !BypassEn && (state_d == StFeed) && (fill_q == FullCount);
        clear_d = !BypassEn && (state_d == StClear);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= StClear;
            fill_q     <= '0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            wren_q     <= 1'b0;
            reen_q     <= 1'b0;
            clear_q    <= !BypassEn;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            sample_l_q <= sample_l_d;
            sample_r_q <= sample_r_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            wren_q     <= wren_d;
            reen_q     <= reen_d;
            clear_q    <= clear_d;
        end
    end

    assign filt_wren       = wren_q;
    assign filt_reen       = reen_q;
    assign filt_clear      = clear_q;
    assign filt_in_left    = sample_l_q;
    assign filt_in_right   = sample_r_q;
    assign writedata_left  = hold_l_q;
    assign writedata_right = hold_r_q;

endmodule

// File: tb/tb_audio_fir_sequencer.sv
// Directed bench for audio_fir_sequencer with N=4; the filter is modelled as out = in+1000 / in-1
// while filt_wren is high.
module tb_audio_fir_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned W = 24;

`ifdef AUDIO_FIR_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic         Clock, Reset;
    logic         read_ready, read, write_ready, write;
    logic [W-1:0] readdata_left, readdata_right, writedata_left, writedata_right;
    logic         filt_wren, filt_reen, filt_clear;
    logic [W-1:0] filt_in_left, filt_in_right, filt_out_left, filt_out_right;

    int checks = 0;
    int errors = 0;

    audio_fir_sequencer #(.N(N), .W(W)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .read_ready     (read_ready),
        .read           (read),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .write_ready    (write_ready),
        .write          (write),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .filt_wren      (filt_wren),
        .filt_reen      (filt_reen),
        .filt_clear     (filt_clear),
        .filt_in_left   (filt_in_left),
        .filt_in_right  (filt_in_right),
        .filt_out_left  (filt_out_left),
        .filt_out_right (filt_out_right)
    );

    assign filt_out_left  = filt_wren ? filt_in_left + 24'd1000 : '0;
    assign filt_out_right = filt_wren ? filt_in_right - 24'd1 : '0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_l(input logic [W-1:0] s);
        return Bypass ? s : s + 24'd1000;
    endfunction

    function automatic logic [W-1:0] exp_r(input logic [W-1:0] s);
        return Bypass ? s : s - 24'd1;
    endfunction

    // Entered at a negedge in IDLE; leaves at a negedge back in IDLE.
    task automatic run_sample(input logic [W-1:0] l, input logic [W-1:0] r,
                              input logic reen_exp, input int wait_n);
        read_ready = 1'b1; readdata_left = l; readdata_right = r;
        #1;
        chk("idle_read", read, 1);
        chk("idle_wren", filt_wren, 0);
        chk("idle_write", write, 0);
        tick();
        read_ready = 1'b0; readdata_left = 24'h0BAD00; readdata_right = 24'h0BAD01;
        #1;
        chk("feed_read", read, 0);
        chk("feed_wren", filt_wren, !Bypass);
        chk("feed_reen", filt_reen, Bypass ? 1'b0 : reen_exp);
        chk("feed_in_l", filt_in_left, l);
        chk("feed_in_r", filt_in_right, r);
        tick();
        read_ready = 1'b1; write_ready = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            #1;
            chk("stall_write", write, 0);
            chk("stall_read", read, 0);
            tick();
        end
        write_ready = 1'b1;
        #1;
        chk("drain_write", write, 1);
        chk("drain_read", read, 0);
        chk("drain_wren", filt_wren, 0);
        chk("wd_left", writedata_left, exp_l(l));
        chk("wd_right", writedata_right, exp_r(r));
        tick();
        write_ready = 1'b0; read_ready = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; read_ready = 1'b0; write_ready = 1'b0;
        readdata_left = '0; readdata_right = '0;
        repeat (3) tick();
        #1;
        chk("rst_clear", filt_clear, !Bypass);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_wren", filt_wren, 0);
        chk("rst_reen", filt_reen, 0);
        chk("rst_wd_l", writedata_left, 0);
        chk("rst_in_r", filt_in_right, 0);
        Reset = 1'b0;
        #1;
        chk("post_rst_clear", filt_clear, !Bypass);
        chk("post_rst_read", read, 0);
        tick();
        #1;
        chk("idle_clear", filt_clear, 0);
        chk("idle_noready_read", read, 0);
        tick();

        // Priming: sample N+1 is the first with filt_reen
        run_sample(24'd100, 24'd101, 1'b0, 0);
        run_sample(24'd200, 24'd201, 1'b0, 0);
        run_sample(24'd300, 24'd301, 1'b0, 0);
        run_sample(24'd400, 24'd401, 1'b0, 0);
        run_sample(24'd500, 24'd501, 1'b1, 0);

        // Output backpressure for 10 cycles
        run_sample(24'd600, 24'd601, 1'b1, 10);

        // Reset in DRAIN after 3 of 4 primed samples
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tick();
        run_sample(24'd10, 24'd11, 1'b0, 0);
        run_sample(24'd20, 24'd21, 1'b0, 0);
        read_ready = 1'b1; readdata_left = 24'd30; readdata_right = 24'd31;
        tick();
        read_ready = 1'b0;
        tick();
        write_ready = 1'b0; Reset = 1'b1;
        #1;
        chk("mid_rst_write", write, 0);
        chk("mid_rst_read", read, 0);
        tick();
        #1;
        chk("mid_rst_clear", filt_clear, !Bypass);
        chk("mid_rst_hold", writedata_left, 0);
        Reset = 1'b0; write_ready = 1'b1;
        tick();
        #1;
        chk("discard_write", write, 0);
        write_ready = 1'b0;
        tick();
        run_sample(24'd40, 24'd41, 1'b0, 0);
        run_sample(24'd50, 24'd51, 1'b0, 0);
        run_sample(24'd60, 24'd61, 1'b0, 0);
        run_sample(24'd70, 24'd71, 1'b0, 0);
        run_sample(24'd80, 24'd81, 1'b1, 0);

        // Continuous readiness: one read every 3 cycles, strobes exclusive
        read_ready = 1'b1; write_ready = 1'b1;
        readdata_left = 24'd700; readdata_right = 24'd701;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("cont_read", read, (i % 3) == 0);
            chk("cont_write", write, (i % 3) == 2);
            chk("cont_wren", filt_wren, !Bypass && ((i % 3) == 1));
            chk("cont_excl", $countones({read, write, filt_wren}) <= 1, 1);
            if ((i % 3) == 2) chk("cont_wd_l", writedata_left, exp_l(24'd700));
            tick();
        end
        read_ready = 1'b0; write_ready = 1'b0;

        // Signed samples pass through bit-exact
        run_sample(24'hFFFFFB, 24'd7, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
